// File: rtl/fg_pkg.sv
// fg_pkg: shared definitions for the function-generator wave shaper.
// Holds the FSM state encoding and helpers for the output saturation limits.
package fg_pkg;

  // Shape FSM states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_ON   = 3'd2,
    ST_FALL = 3'd3,
    ST_OFF  = 3'd4
  } fg_state_e;

  // Most positive output code for a WBW+1 bit signed output
  function automatic int fg_sat_hi(input int wbw);
    return (1 << wbw) - 1;
  endfunction

  // Most negative output code for a WBW+1 bit signed output
  function automatic int fg_sat_lo(input int wbw);
    return -(1 << wbw);
  endfunction

endpackage

// File: rtl/fg_out_sat.sv
// fg_out_sat: output stage of the wave generator.
// Optionally negates the unsigned shape value, adds a signed offset and
// saturates to the signed WBW+1 bit output range before registering it.
module fg_out_sat
  import fg_pkg::*;
#(
  parameter int WBW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clk_en_i,
  input  logic [WBW-1:0]      val_i,
  input  logic                invert_i,
  input  logic signed [WBW:0] offset_i,
  output logic signed [WBW:0] out_o
);

  localparam logic signed [WBW+1:0] SAT_HI = (WBW+2)'(fg_sat_hi(WBW));
  localparam logic signed [WBW+1:0] SAT_LO = (WBW+2)'(fg_sat_lo(WBW));

  logic signed [WBW+1:0] w_mag;
  logic signed [WBW+1:0] w_p;
  logic signed [WBW+1:0] w_q;
  logic signed [WBW:0]   w_sat;
  logic signed [WBW:0]   r_out;

  // Two extra bits cover both the negation and the offset sum without overflow
  assign w_mag = $signed({2'b00, val_i});
  assign w_p   = invert_i ? -w_mag : w_mag;
  assign w_q   = w_p + $signed({offset_i[WBW], offset_i});

  // Clamp the widened sum into the representable output range
  always_comb begin
    if (w_q > SAT_HI) begin
      w_sat = SAT_HI[WBW:0];
    end else if (w_q < SAT_LO) begin
      w_sat = SAT_LO[WBW:0];
    end else begin
      w_sat = w_q[WBW:0];
    end
  end

  // Output register, advanced only on enabled ticks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out <= '0;
    end else if (clk_en_i) begin
      r_out <= w_sat;
    end
  end

  assign out_o = r_out;

endmodule

// File: rtl/fg_wavegen_v2.sv
// fg_wavegen_v2: free-running trapezoid/triangle/square generator.
// Owns its period counter, double-buffers the shape config (applied only at
// period restarts) and feeds fg_out_sat for invert/offset/saturation.
// Optional burst mode (burst_len_i, done_o) is built when FG_BURST_EN is defined.
module fg_wavegen_v2
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH  = 32,
  parameter int WAVEFORM_BITWIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clk_en_i,
  input  logic                              en_i,
  input  logic                              cfg_we_i,
  input  logic [COUNTER_BITWIDTH-1:0]       period_i,
  input  logic [COUNTER_BITWIDTH-1:0]       on_time_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]      amplitude_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]      k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]      k_fall_i,
  input  logic signed [WAVEFORM_BITWIDTH:0] offset_i,
  input  logic                              invert_i,
`ifdef FG_BURST_EN
  input  logic [15:0]                       burst_len_i,
  output logic                              done_o,
`endif
  output logic signed [WAVEFORM_BITWIDTH:0] out_o,
  output logic                              period_start_o,
  output logic [2:0]                        state_o
);

  localparam int CBW = COUNTER_BITWIDTH;
  localparam int WBW = WAVEFORM_BITWIDTH;

  logic [CBW-1:0]      r_sh_period, r_sh_on, r_act_period, r_act_on, r_cnt;
  logic [WBW-1:0]      r_sh_amp, r_sh_kr, r_sh_kf;
  logic [WBW-1:0]      r_act_amp, r_act_kr, r_act_kf, r_val;
  logic signed [WBW:0] r_sh_off, r_act_off;
  logic                r_sh_inv, r_act_inv;
  fg_state_e           r_state;
  logic                r_pstart;

  logic                w_is_rise;
  logic [WBW:0]        w_opb;
  logic [WBW:0]        w_sum;
  logic                w_rise_top, w_fall_low;
  logic [WBW-1:0]      w_rise_val, w_fall_val;
  logic                w_period_end, w_stop, w_blocked, w_restart;

  // Single shared adder: val+k_rise while rising, val-k_fall (two's complement) otherwise
  assign w_is_rise = (r_state == ST_RISE);
  assign w_opb     = w_is_rise ? {1'b0, r_act_kr} : ~{1'b0, r_act_kf};
  assign w_sum     = {1'b0, r_val} + w_opb + {{WBW{1'b0}}, ~w_is_rise};

  assign w_rise_top = (w_sum >= {1'b0, r_act_amp});
  assign w_rise_val = w_rise_top ? r_act_amp : w_sum[WBW-1:0];
  assign w_fall_low = w_sum[WBW] || (w_sum == '0);
  assign w_fall_val = w_fall_low ? '0 : w_sum[WBW-1:0];

  assign w_period_end = (r_cnt == r_act_period);

`ifdef FG_BURST_EN
  logic [15:0] r_sh_burst, r_act_burst, r_burst_cnt;
  logic        r_done;
  logic        w_burst_last;

  assign w_burst_last = (r_act_burst != 16'd0) && (r_burst_cnt == r_act_burst - 16'd1);
  assign w_stop       = en_i && (r_state != ST_IDLE) && w_period_end && w_burst_last;
  assign w_blocked    = r_done;

  // Burst bookkeeping: shadowed length, completed-period count and sticky done flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sh_burst  <= '0;
      r_act_burst <= '0;
      r_burst_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        r_sh_burst <= burst_len_i;
      end
      if (clk_en_i) begin
        if (!en_i) begin
          r_done <= 1'b0;
        end else if (w_stop) begin
          r_done <= 1'b1;
        end else if (w_restart) begin
          r_act_burst <= r_sh_burst;
          r_burst_cnt <= (r_state == ST_IDLE) ? 16'd0 : r_burst_cnt + 16'd1;
        end
      end
    end
  end

  assign done_o = r_done;
`else
  assign w_stop    = 1'b0;
  assign w_blocked = 1'b0;
`endif

  assign w_restart = en_i && !w_blocked && ((r_state == ST_IDLE) || w_period_end);

  // Shadow config capture on every clock, independent of the tick enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sh_period <= '0;
      r_sh_on     <= '0;
      r_sh_amp    <= '0;
      r_sh_kr     <= '0;
      r_sh_kf     <= '0;
      r_sh_off    <= '0;
      r_sh_inv    <= 1'b0;
    end else if (cfg_we_i) begin
      r_sh_period <= period_i;
      r_sh_on     <= on_time_i;
      r_sh_amp    <= amplitude_i;
      r_sh_kr     <= k_rise_i;
      r_sh_kf     <= k_fall_i;
      r_sh_off    <= offset_i;
      r_sh_inv    <= invert_i;
    end
  end

  // Period counter, shape FSM and active-config load at each restart
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_act_period <= '0;
      r_act_on     <= '0;
      r_act_amp    <= '0;
      r_act_kr     <= '0;
      r_act_kf     <= '0;
      r_act_off    <= '0;
      r_act_inv    <= 1'b0;
      r_cnt        <= '0;
      r_val        <= '0;
      r_state      <= ST_IDLE;
      r_pstart     <= 1'b0;
    end else begin
      r_pstart <= 1'b0;
      if (clk_en_i) begin
        if (!en_i || w_stop) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_val   <= '0;
        end else if (w_restart) begin
          r_act_period <= r_sh_period;
          r_act_on     <= r_sh_on;
          r_act_amp    <= r_sh_amp;
          r_act_kr     <= r_sh_kr;
          r_act_kf     <= r_sh_kf;
          r_act_off    <= r_sh_off;
          r_act_inv    <= r_sh_inv;
          r_cnt        <= '0;
          r_val        <= '0;
          r_state      <= ST_RISE;
          r_pstart     <= 1'b1;
        end else if (r_state != ST_IDLE) begin
          r_cnt <= r_cnt + CBW'(1);
          case (r_state)
            ST_RISE: begin
              r_val <= w_rise_val;
              if (w_rise_top) r_state <= ST_ON;
            end
            ST_ON: r_val <= r_act_amp;
            ST_FALL: begin
              r_val <= w_fall_val;
              if (w_fall_low) r_state <= ST_OFF;
            end
            default: r_val <= '0;
          endcase
          // on_time overrides the level-based transition; val still follows the old state
          if (r_cnt == r_act_on) r_state <= ST_FALL;
        end
      end
    end
  end

  assign period_start_o = r_pstart;
  assign state_o        = r_state;

  fg_out_sat #(
    .WBW(WBW)
  ) u_out_sat (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_en_i (clk_en_i),
    .val_i    (r_val),
    .invert_i (r_act_inv),
    .offset_i (r_act_off),
    .out_o    (out_o)
  );

endmodule

// File: tb/tb_fg_wavegen_v2.sv
// tb_fg_wavegen_v2: directed scenarios plus randomized traffic, checked against
// a per-period shape model (value/state derived from the tick index in the period).
module tb_fg_wavegen_v2;

  localparam int CBW = 16;
  localparam int WBW = 8;
  localparam int SAT_HI = (1 << WBW) - 1;
  localparam int SAT_LO = -(1 << WBW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, clk_en, en, cfg_we, inv;
  logic [CBW-1:0]      period, on_time;
  logic [WBW-1:0]      amp, kr, kf;
  logic signed [WBW:0] off;
  logic signed [WBW:0] out;
  logic                pstart;
  logic [2:0]          state;
`ifdef FG_BURST_EN
  logic [15:0]         burst_len;
  logic                done;
`endif

  int checks = 0;
  int failures = 0;

  fg_wavegen_v2 #(
    .COUNTER_BITWIDTH  (CBW),
    .WAVEFORM_BITWIDTH (WBW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_en_i       (clk_en),
    .en_i           (en),
    .cfg_we_i       (cfg_we),
    .period_i       (period),
    .on_time_i      (on_time),
    .amplitude_i    (amp),
    .k_rise_i       (kr),
    .k_fall_i       (kf),
    .offset_i       (off),
    .invert_i       (inv),
`ifdef FG_BURST_EN
    .burst_len_i    (burst_len),
    .done_o         (done),
`endif
    .out_o          (out),
    .period_start_o (pstart),
    .state_o        (state)
  );

  // ---------------- reference model ----------------
  int s_per, s_on, s_amp, s_kr, s_kf, s_off, s_inv, s_bl;
  int a_per, a_on, a_amp, a_kr, a_kf, a_off, a_inv, a_bl;
  int m_run, m_pos, m_done, m_bcnt, m_out, m_ps;

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Shape value i ticks after the restart: clamped ramp up to on_time+1, then linear fall
  function automatic int shape_val(input int i);
    int peak;
    if (i <= a_on + 1) return imin(i * a_kr, a_amp);
    peak = imin((a_on + 1) * a_kr, a_amp);
    return (peak - (i - a_on - 1) * a_kf > 0) ? peak - (i - a_on - 1) * a_kf : 0;
  endfunction

  function automatic int model_val();
    return (m_run != 0 && m_pos > 0) ? shape_val(m_pos) : 0;
  endfunction

  // 0 idle, 1 rise, 2 plateau, 3 fall, 4 off
  function automatic int model_state();
    if (m_run == 0) return 0;
    if (m_pos == 0) return 1;
    if (m_pos <= a_on) return (m_pos * a_kr >= a_amp) ? 2 : 1;
    if (m_pos == a_on + 1) return 3;
    return (shape_val(m_pos) > 0) ? 3 : 4;
  endfunction

  task automatic model_step();
    int v, q;
    if (rst) begin
      {s_per, s_on, s_amp, s_kr, s_kf, s_off, s_inv, s_bl} = '0;
      {a_per, a_on, a_amp, a_kr, a_kf, a_off, a_inv, a_bl} = '0;
      m_run = 0; m_pos = 0; m_done = 0; m_bcnt = 0; m_out = 0; m_ps = 0;
      return;
    end
    m_ps = 0;
    if (clk_en) begin
      v = model_val();
      q = (a_inv != 0 ? -v : v) + a_off;
      m_out = (q > SAT_HI) ? SAT_HI : ((q < SAT_LO) ? SAT_LO : q);
      if (!en) begin
        m_run = 0; m_pos = 0; m_done = 0;
      end else if (m_run != 0 && m_pos == a_per && a_bl != 0 && m_bcnt == a_bl - 1) begin
        m_run = 0; m_pos = 0; m_done = 1;
      end else if (m_done == 0 && (m_run == 0 || m_pos == a_per)) begin
        m_bcnt = (m_run != 0) ? m_bcnt + 1 : 0;
        a_per = s_per; a_on = s_on; a_amp = s_amp; a_kr = s_kr;
        a_kf = s_kf; a_off = s_off; a_inv = s_inv; a_bl = s_bl;
        m_run = 1; m_pos = 0; m_ps = 1;
      end else if (m_run != 0) begin
        m_pos++;
      end
    end
    if (cfg_we) begin
      s_per = period; s_on = on_time; s_amp = amp; s_kr = kr; s_kf = kf;
      s_off = off; s_inv = inv;
`ifdef FG_BURST_EN
      s_bl = burst_len;
`endif
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_value(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_value("out", out, m_out);
    check_value("pstart", {31'd0, pstart}, m_ps);
    check_value("state", {29'd0, state}, model_state());
`ifdef FG_BURST_EN
    check_value("done", {31'd0, done}, m_done);
`endif
  endtask

  task automatic set_cfg(input int p, input int o, input int a, input int r,
                         input int f, input int ofs, input bit i);
    period = p[CBW-1:0]; on_time = o[CBW-1:0]; amp = a[WBW-1:0];
    kr = r[WBW-1:0]; kf = f[WBW-1:0]; off = ofs[WBW:0]; inv = i;
    cfg_we = 1'b1;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    cycle();
    while (pstart !== 1'b1 && n < 80) begin cycle(); n++; end
    check_value("wait_pstart", {31'd0, pstart}, 1);
  endtask

  task automatic wait_state(input int target);
    int n = 0;
    while (int'(state) != target && n < 80) begin cycle(); n++; end
    check_value("wait_state", {29'd0, state}, target);
  endtask

  int exp_t1[10] = '{0, 40, 80, 100, 100, 100, 100, 50, 0, 0};
  int cnt;

  initial begin
    rst = 1'b1; clk_en = 1'b1; en = 1'b0; cfg_we = 1'b0; inv = 1'b0;
    period = '0; on_time = '0; amp = '0; kr = '0; kf = '0; off = '0;
`ifdef FG_BURST_EN
    burst_len = '0;
`endif
    cycle(); cycle();
    rst = 1'b0;
    check_value("rst_out", out, 0);
    check_value("rst_state", {29'd0, state}, 0);
    check_value("rst_pstart", {31'd0, pstart}, 0);

    // 1: basic trapezoid
    set_cfg(9, 5, 100, 40, 50, 0, 0);
    en = 1'b1;
    cycle();
    check_value("t1_first_pstart", {31'd0, pstart}, 1);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check_value("t1_out", out, exp_t1[k]);
    end
    cnt = 0;
    for (int k = 0; k < 20; k++) begin cycle(); cnt += int'(pstart); end
    check_value("t1_pstart_count", cnt, 2);
    $display("scenario basic trapezoid complete");

    // 2: saturation both ways
    set_cfg(9, 5, 100, 40, 50, -200, 1);
    wait_ps(); wait_state(2); cycle();
    check_value("t2_sat_lo", out, -256);
    set_cfg(9, 5, 100, 40, 50, 200, 0);
    wait_ps(); wait_state(2); cycle();
    check_value("t2_sat_hi", out, 255);
    $display("scenario saturation complete");

    // 3: mid-period config write applies only after the next restart
    set_cfg(9, 5, 100, 40, 50, 0, 0);
    wait_ps();
    cycle(); cycle(); cycle();
    set_cfg(9, 5, 50, 40, 50, 0, 0);
    wait_state(2); cycle();
    check_value("t3_old_plateau", out, 100);
    wait_ps(); wait_state(2); cycle();
    check_value("t3_new_plateau", out, 50);
    $display("scenario mid-period config complete");

    // 4: on_time beyond period never reaches FALL
    set_cfg(9, 20, 100, 40, 50, 30, 0);
    wait_ps();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin cycle(); cnt += (state == 3'd3) ? 1 : 0; end
    check_value("t4_no_fall", cnt, 0);
    $display("scenario truncated shape complete");

    // 5: stop, reset, tick freeze
    wait_ps();
    en = 1'b0;
    cycle();
    check_value("t5_idle", {29'd0, state}, 0);
    cycle();
    check_value("t5_offset_only", out, 30);
    en = 1'b1;
    wait_state(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_value("t5_rst_out", out, 0);
    check_value("t5_rst_state", {29'd0, state}, 0);
    check_value("t5_rst_pstart", {31'd0, pstart}, 0);
    set_cfg(9, 5, 100, 40, 50, -20, 0);
    wait_state(2);
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    check_value("t5_freeze", out, 60);
    clk_en = 1'b1;
    $display("scenario stop/reset/freeze complete");

`ifdef FG_BURST_EN
    // 6: burst of two periods
    en = 1'b0;
    cycle();
    burst_len = 16'd2;
    set_cfg(9, 5, 100, 40, 50, 0, 0);
    en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin cycle(); cnt += int'(pstart); end
    check_value("t6_burst_pulses", cnt, 2);
    check_value("t6_idle", {29'd0, state}, 0);
    check_value("t6_done", {31'd0, done}, 1);
    en = 1'b0;
    cycle();
    check_value("t6_done_clear", {31'd0, done}, 0);
    burst_len = 16'd0;
    en = 1'b1;
    $display("scenario burst complete");
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      clk_en = ($urandom_range(0, 4) != 0);
      en     = ($urandom_range(0, 29) != 0);
      cfg_we = ($urandom_range(0, 14) == 0);
      if (cfg_we) begin
        period  = CBW'($urandom_range(0, 12));
        on_time = CBW'($urandom_range(0, 14));
        amp     = WBW'($urandom);
        kr      = WBW'($urandom_range(0, 80));
        kf      = WBW'($urandom_range(0, 80));
        off     = (WBW+1)'($urandom);
        inv     = 1'($urandom);
`ifdef FG_BURST_EN
        burst_len = 16'($urandom_range(0, 3));
`endif
      end
      cycle();
    end
    $display("scenario random traffic complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
